// File: rtl/launcher_pkg.sv
// ============================================================================
// Module      : launcher_pkg
// Description : Shared state encodings and defaults for riscv_kernel_launcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package launcher_pkg;

  localparam logic [2:0] c_StIdle  = 3'd0;
  localparam logic [2:0] c_StLoad  = 3'd1;
  localparam logic [2:0] c_StStart = 3'd2;
  localparam logic [2:0] c_StRun   = 3'd3;
  localparam logic [2:0] c_StRead  = 3'd4;
  localparam logic [2:0] c_StError = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = c_StIdle,
    S_LOAD  = c_StLoad,
    S_START = c_StStart,
    S_RUN   = c_StRun,
    S_READ  = c_StRead,
    S_ERROR = c_StError
  } state_t;

  localparam int c_DefaultTimeout = 4096;

endpackage

`default_nettype wire

// File: rtl/launcher_rd_buf.sv
// ============================================================================
// Module      : launcher_rd_buf
// Description : Two-entry valid/ready FIFO with occupancy output.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module launcher_rd_buf #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pushValid,
  input  logic [WIDTH-1:0] pushData,
  output logic             popValid,
  input  logic             popReady,
  output logic [WIDTH-1:0] popData,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] r_mem [2];
  logic             r_wrPtr;
  logic             r_rdPtr;
  logic [1:0]       r_count;
  logic             w_push;
  logic             w_pop;

  assign w_push   = pushValid & (r_count != 2'd2);
  assign w_pop    = popValid & popReady;
  assign popValid = (r_count != 2'd0);
  assign popData  = r_mem[r_rdPtr];
  assign count    = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr] <= pushData;
        r_wrPtr        <= ~r_wrPtr;
      end
      if (w_pop) begin
        r_rdPtr <= ~r_rdPtr;
      end
      r_count <= r_count + {1'b0, w_push} - {1'b0, w_pop};
    end
  end

endmodule

`default_nettype wire

// File: rtl/riscv_kernel_launcher.sv
// ============================================================================
// Module      : riscv_kernel_launcher
// Description : Loads imem, launches the core, waits for done with timeout and
//               streams dmem back. LAUNCHER_CHECKSUM_EN appends a sum word.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module riscv_kernel_launcher
  import launcher_pkg::*;
#(
  parameter int ADDRESS_WIDTH_IMEM = 6,
  parameter int ADDRESS_WIDTH_DMEM = 5,
  parameter int IMEM_SIZE          = 40,
  parameter int DMEM_SIZE          = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int TIMEOUT_CYCLES     = c_DefaultTimeout
) (
  input  logic                          ap_clk,
  input  logic                          ap_rst,
  input  logic                          cmd_start,
  input  logic                          prog_valid,
  output logic                          prog_ready,
  input  logic [DATA_WIDTH-1:0]         prog_data,
  output logic [ADDRESS_WIDTH_IMEM-1:0] imem_wr_address,
  output logic                          imem_wr_en,
  output logic [DATA_WIDTH-1:0]         imem_wr_data,
  output logic [ADDRESS_WIDTH_DMEM-1:0] dmem_rd_address,
  output logic                          dmem_rd_ce,
  input  logic [DATA_WIDTH-1:0]         dmem_rd_q,
  output logic                          kernel_rst,
  output logic                          kernel_start,
  input  logic                          kernel_done,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [DATA_WIDTH-1:0]         res_data,
  output logic                          busy,
  output logic                          error
);

  localparam int c_WordCntW = $clog2(IMEM_SIZE + 1);
  localparam int c_RdCntW   = $clog2(DMEM_SIZE + 1);
  localparam int c_CycCntW  = $clog2(TIMEOUT_CYCLES + 1);
`ifdef LAUNCHER_CHECKSUM_EN
  localparam int c_ResTotal = DMEM_SIZE + 1;
`else
  localparam int c_ResTotal = DMEM_SIZE;
`endif
  localparam int c_ResCntW  = $clog2(c_ResTotal + 1);

  state_t                  r_state;
  logic [c_WordCntW-1:0]   r_wordCnt;
  logic [c_CycCntW-1:0]    r_cycCnt;
  logic [c_RdCntW-1:0]     r_rdAddr;
  logic [c_ResCntW-1:0]    r_resCnt;
  logic                    r_inFlight;
  logic                    r_kernelRst;
  logic                    r_kernelStart;
  logic                    r_busy;
  logic                    r_error;

  logic                    w_accept;
  logic                    w_issue;
  logic                    w_pop;
  logic                    w_lastRes;
  logic [2:0]              w_occ;
  logic                    w_bufValid;
  logic                    w_bufPop;
  logic [DATA_WIDTH-1:0]   w_bufData;
  logic [1:0]              w_bufCount;

  assign w_accept        = (r_state == S_LOAD) & prog_valid;
  assign prog_ready      = (r_state == S_LOAD);
  assign imem_wr_en      = w_accept;
  assign imem_wr_address = ADDRESS_WIDTH_IMEM'(r_wordCnt);
  assign imem_wr_data    = w_accept ? prog_data : '0;

  // Occupancy counts the word in flight and frees the slot popped this cycle,
  // which is what lets a 2-entry buffer sustain one word per cycle.
  assign w_bufPop  = w_bufValid & res_ready;
  assign w_occ     = {1'b0, w_bufCount} + {2'b00, r_inFlight} - {2'b00, w_bufPop};
  assign w_issue   = (r_state == S_READ) && (r_rdAddr < c_RdCntW'(DMEM_SIZE)) && (w_occ < 3'd2);
  assign dmem_rd_ce      = w_issue;
  assign dmem_rd_address = ADDRESS_WIDTH_DMEM'(r_rdAddr);

  launcher_rd_buf #(
    .WIDTH (DATA_WIDTH)
  ) u_rdBuf (
    .clk       (ap_clk),
    .rst       (ap_rst),
    .pushValid (r_inFlight),
    .pushData  (dmem_rd_q),
    .popValid  (w_bufValid),
    .popReady  (res_ready),
    .popData   (w_bufData),
    .count     (w_bufCount)
  );

`ifdef LAUNCHER_CHECKSUM_EN
  logic [DATA_WIDTH-1:0] r_sum;
  logic                  w_sumPhase;

  assign w_sumPhase = (r_state == S_READ) && (r_resCnt == c_ResCntW'(DMEM_SIZE));
  assign res_valid  = w_bufValid | w_sumPhase;
  assign res_data   = w_sumPhase ? r_sum : (w_bufValid ? w_bufData : '0);

  always_ff @(posedge ap_clk) begin
    if (ap_rst || r_state != S_READ) begin
      r_sum <= '0;
    end else if (w_bufPop) begin
      r_sum <= r_sum + w_bufData;
    end
  end
`else
  assign res_valid = w_bufValid;
  assign res_data  = w_bufValid ? w_bufData : '0;
`endif

  assign w_pop     = res_valid & res_ready;
  assign w_lastRes = (r_resCnt == c_ResCntW'(c_ResTotal - 1));

  assign kernel_rst   = r_kernelRst;
  assign kernel_start = r_kernelStart;
  assign busy         = r_busy;
  assign error        = r_error;

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      r_state       <= S_IDLE;
      r_wordCnt     <= '0;
      r_cycCnt      <= '0;
      r_rdAddr      <= '0;
      r_resCnt      <= '0;
      r_inFlight    <= 1'b0;
      r_kernelRst   <= 1'b1;
      r_kernelStart <= 1'b0;
      r_busy        <= 1'b0;
      r_error       <= 1'b0;
    end else begin
      r_inFlight <= w_issue;
      case (r_state)
        S_IDLE, S_ERROR: begin
          if (cmd_start) begin
            r_state   <= S_LOAD;
            r_wordCnt <= '0;
            r_error   <= 1'b0;
            r_busy    <= 1'b1;
          end
        end
        S_LOAD: begin
          if (prog_valid) begin
            r_wordCnt <= r_wordCnt + c_WordCntW'(1);
            if (r_wordCnt == c_WordCntW'(IMEM_SIZE - 1)) begin
              r_state       <= S_START;
              r_kernelRst   <= 1'b0;
              r_kernelStart <= 1'b1;
            end
          end
        end
        S_START: begin
          r_state       <= S_RUN;
          r_kernelStart <= 1'b0;
          r_cycCnt      <= '0;
        end
        S_RUN: begin
          if (kernel_done) begin
            r_state     <= S_READ;
            r_kernelRst <= 1'b1;
            r_rdAddr    <= '0;
            r_resCnt    <= '0;
          end else if (r_cycCnt == c_CycCntW'(TIMEOUT_CYCLES - 1)) begin
            r_state     <= S_ERROR;
            r_kernelRst <= 1'b1;
            r_error     <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_cycCnt <= r_cycCnt + c_CycCntW'(1);
          end
        end
        S_READ: begin
          if (w_issue) begin
            r_rdAddr <= r_rdAddr + c_RdCntW'(1);
          end
          if (w_pop) begin
            r_resCnt <= r_resCnt + c_ResCntW'(1);
            if (w_lastRes) begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_riscv_kernel_launcher.sv
// ============================================================================
// Module      : tb_riscv_kernel_launcher
// Description : Directed, table-driven bench for riscv_kernel_launcher.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_riscv_kernel_launcher;

  localparam int IMEM = 40;
  localparam int DMEM = 32;
  localparam int TMO  = 64;
`ifdef LAUNCHER_CHECKSUM_EN
  localparam int EXP_WORDS = DMEM + 1;
`else
  localparam int EXP_WORDS = DMEM;
`endif

  typedef struct {
    int doneAt;
    bit randReady;
    bit gaps;
    int seed;
    bit expTimeout;
  } vec_t;

  logic        clk = 1'b0;
  logic        ap_rst, cmd_start, prog_valid, prog_ready;
  logic [31:0] prog_data;
  logic [5:0]  imem_wr_address;
  logic        imem_wr_en;
  logic [31:0] imem_wr_data;
  logic [4:0]  dmem_rd_address;
  logic        dmem_rd_ce;
  logic [31:0] dmem_rd_q;
  logic        kernel_rst, kernel_start, kernel_done;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        busy, error;

  logic [31:0] imemModel [64];
  logic [31:0] dmemModel [DMEM];
  int          wrCount = 0;
  int          startCount = 0;
  int          nCmp = 0;
  int          nErr = 0;
  vec_t        tbl [4];

  always #5 clk = ~clk;

  riscv_kernel_launcher #(
    .ADDRESS_WIDTH_IMEM (6),
    .ADDRESS_WIDTH_DMEM (5),
    .IMEM_SIZE          (IMEM),
    .DMEM_SIZE          (DMEM),
    .DATA_WIDTH         (32),
    .TIMEOUT_CYCLES     (TMO)
  ) dut (
    .ap_clk          (clk),
    .ap_rst          (ap_rst),
    .cmd_start       (cmd_start),
    .prog_valid      (prog_valid),
    .prog_ready      (prog_ready),
    .prog_data       (prog_data),
    .imem_wr_address (imem_wr_address),
    .imem_wr_en      (imem_wr_en),
    .imem_wr_data    (imem_wr_data),
    .dmem_rd_address (dmem_rd_address),
    .dmem_rd_ce      (dmem_rd_ce),
    .dmem_rd_q       (dmem_rd_q),
    .kernel_rst      (kernel_rst),
    .kernel_start    (kernel_start),
    .kernel_done     (kernel_done),
    .res_valid       (res_valid),
    .res_ready       (res_ready),
    .res_data        (res_data),
    .busy            (busy),
    .error           (error)
  );

  // imem/dmem models on the launcher-owned RAM ports
  always @(posedge clk) begin
    if (imem_wr_en) begin
      imemModel[imem_wr_address] <= imem_wr_data;
      wrCount <= wrCount + 1;
    end
    if (dmem_rd_ce) dmem_rd_q <= dmemModel[dmem_rd_address];
    if (kernel_start) startCount <= startCount + 1;
  end

  function automatic logic [31:0] progWord(input int i, input int seed);
    return 32'h13 | (32'(i) << 7) | (32'(seed) << 20);
  endfunction

  function automatic logic [31:0] dmemWord(input int i, input int seed);
    return (seed == 0) ? 32'(i + 1) : ((32'(i) * 32'h01000193) ^ (32'(seed) << 16));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCmp++;
    if (act !== exp) begin
      nErr++;
      $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic resetCheck(input string tag);
    chk({tag, "_kernel_rst"}, kernel_rst, 1);
    chk({tag, "_kernel_start"}, kernel_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_error"}, error, 0);
    chk({tag, "_prog_ready"}, prog_ready, 0);
    chk({tag, "_imem_wr_en"}, imem_wr_en, 0);
    chk({tag, "_dmem_rd_ce"}, dmem_rd_ce, 0);
    chk({tag, "_res_valid"}, res_valid, 0);
  endtask

  task automatic launch(input vec_t v);
    int i, guard, bad, wrBase, startBase, n, firstV, lastV, badBusy;
    logic [31:0] sum, exp;
    for (int j = 0; j < DMEM; j++) dmemModel[j] = dmemWord(j, v.seed);
    wrBase = wrCount;
    startBase = startCount;
    @(negedge clk); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    #1;
    chk("load_prog_ready", prog_ready, 1);
    chk("load_busy", busy, 1);
    chk("load_error_cleared", error, 0);
    chk("load_kernel_rst", kernel_rst, 1);
    i = 0; guard = 0;
    while (i < IMEM && guard < 400) begin
      guard++;
      if (v.gaps && $urandom_range(0, 2) == 0) begin
        prog_valid = 1'b0;
        #1;
        chk("gap_no_write", imem_wr_en, 0);
      end else begin
        prog_valid = 1'b1;
        prog_data  = progWord(i, v.seed);
        #1;
        chk("imem_wr_en", imem_wr_en, 1);
        chk($sformatf("imem_wr_addr[%0d]", i), imem_wr_address, i);
        i++;
      end
      @(negedge clk);
    end
    prog_valid = 1'b0;
    #1;
    chk("load_count", i, IMEM);
    chk("kernel_start_pulse", kernel_start, 1);
    chk("kernel_rst_released", kernel_rst, 0);
    chk("imem_writes", wrCount - wrBase, IMEM);
    bad = 0;
    for (int j = 0; j < IMEM; j++) if (imemModel[j] !== progWord(j, v.seed)) bad++;
    chk("imem_contents", bad, 0);
    @(negedge clk); #1;
    chk("kernel_start_low", kernel_start, 0);
    for (int k = 0; k < TMO + 4; k++) begin
      cmd_start   = (k == 2);
      prog_valid  = (k == 2);
      kernel_done = (k == v.doneAt);
      #1;
      if (k == 2) begin
        chk("prog_ignored_run", imem_wr_en, 0);
        chk("prog_ready_run", prog_ready, 0);
      end
      if (k == 3) begin
        chk("kernel_rst_run", kernel_rst, 0);
        chk("cmd_ignored_run", busy, 1);
        chk("start_once", startCount - startBase, 1);
      end
      if (v.doneAt < 0 && k == TMO - 1) chk("no_early_timeout", error, 0);
      if (k == v.doneAt || (v.doneAt < 0 && k == TMO - 1)) break;
      @(negedge clk);
    end
    @(negedge clk);
    kernel_done = 1'b0; cmd_start = 1'b0; prog_valid = 1'b0;
    #1;
    if (v.expTimeout) begin
      chk("timeout_error", error, 1);
      chk("timeout_kernel_rst", kernel_rst, 1);
      chk("timeout_busy", busy, 0);
      bad = 0;
      repeat (5) begin
        bad += int'(res_valid | dmem_rd_ce);
        @(negedge clk); #1;
      end
      chk("timeout_no_read", bad, 0);
      chk("error_sticky", error, 1);
      return;
    end
    chk("done_kernel_rst", kernel_rst, 1);
    chk("done_no_error", error, 0);
    n = 0; firstV = -1; lastV = -1; sum = '0; badBusy = 0;
    for (int c = 0; c < 600 && n < EXP_WORDS; c++) begin
      if (c > 0) @(negedge clk);
      res_ready = v.randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      #1;
      badBusy += int'(!busy);
      if (res_valid && firstV < 0) firstV = c;
      if (res_valid && res_ready) begin
        exp = (n < DMEM) ? dmemModel[n] : sum;
        chk($sformatf("res_data[%0d]", n), res_data, exp);
`ifdef LAUNCHER_CHECKSUM_EN
        if (n == DMEM && v.seed == 0) chk("checksum_528", res_data, 32'd528);
`endif
        if (n < DMEM) sum += exp;
        n++;
        lastV = c;
      end
    end
    chk("res_count", n, EXP_WORDS);
    chk("busy_during_read", badBusy, 0);
    if (!v.randReady) begin
      chk("first_valid_cycle", firstV, 2);
      chk("back_to_back", lastV - firstV, EXP_WORDS - 1);
    end
    @(negedge clk); res_ready = 1'b0; #1;
    chk("busy_after_last", busy, 0);
    chk("kernel_rst_after_read", kernel_rst, 1);
    chk("res_valid_idle", res_valid, 0);
  endtask

  initial begin
    tbl[0] = '{doneAt: 5,  randReady: 1'b0, gaps: 1'b0, seed: 0, expTimeout: 1'b0};
    tbl[1] = '{doneAt: 63, randReady: 1'b1, gaps: 1'b1, seed: 1, expTimeout: 1'b0};
    tbl[2] = '{doneAt: -1, randReady: 1'b0, gaps: 1'b0, seed: 2, expTimeout: 1'b1};
    tbl[3] = '{doneAt: 40, randReady: 1'b1, gaps: 1'b1, seed: 3, expTimeout: 1'b0};

    ap_rst = 1'b1; cmd_start = 1'b0; prog_valid = 1'b0; prog_data = '0;
    kernel_done = 1'b0; res_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    resetCheck("reset");
    ap_rst = 1'b0;

    for (int t = 0; t < 4; t++) launch(tbl[t]);

    // reset pulse in the middle of a program load, then a clean launch
    @(negedge clk); cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    for (int i = 0; i < 18; i++) begin
      prog_valid = 1'b1;
      prog_data  = progWord(i, 7);
      @(negedge clk);
    end
    prog_valid = 1'b0;
    ap_rst = 1'b1;
    @(negedge clk); #1;
    resetCheck("midload_reset");
    ap_rst = 1'b0;
    launch(tbl[0]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
